// File: rtl/vin_pkg.sv
// Shared definitions for the vin synthetic video source: pattern encodings,
// color-bar palette and a width helper for counter/coordinate sizing.
package vin_pkg;

   typedef enum logic [1:0] {
      PAT_SOLID = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_BARS  = 2'd2,
      PAT_CHECK = 2'd3
   } pattern_e;

   // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
   localparam logic [7:0][23:0] BAR_RGB = {
      24'h000000,
      24'h0000FF,
      24'hFF0000,
      24'hFF00FF,
      24'h00FF00,
      24'h00FFFF,
      24'hFFFF00,
      24'hFFFFFF
   };

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vin_timing_gen.sv
// Raster timing for the vin pattern generator: horizontal/vertical counters
// and the combinational sync, active-video and coordinate decode of their state.
module vin_timing_gen
   import vin_pkg::*;
#(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 8,
   parameter int H_SYNC   = 4,
   parameter int H_BP     = 8,
   parameter int V_ACTIVE = 1200,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 4,
   parameter int COL_W    = width_of(H_ACTIVE),
   parameter int ROW_W    = width_of(V_ACTIVE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             hsync,
   output logic             vsync,
   output logic             valid,
   output logic             frame_start,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HCNT_W  = width_of(H_TOTAL);
   localparam int VCNT_W  = width_of(V_TOTAL);
   localparam int H_BEG   = H_SYNC + H_BP;
   localparam int H_END   = H_BEG + H_ACTIVE;
   localparam int V_BEG   = V_SYNC + V_BP;
   localparam int V_END   = V_BEG + V_ACTIVE;

   logic [HCNT_W-1:0] hcnt;
   logic [VCNT_W-1:0] vcnt;
   logic              h_act;
   logic              v_act;

   // Dropping en parks both counters at the frame origin, so re-enabling
   // always begins a fresh frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (!en) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == HCNT_W'(H_TOTAL - 1)) begin
         hcnt <= '0;
         vcnt <= (vcnt == VCNT_W'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

   assign hsync       = (hcnt < HCNT_W'(H_SYNC));
   assign vsync       = (vcnt < VCNT_W'(V_SYNC));
   assign h_act       = (hcnt >= HCNT_W'(H_BEG)) && (hcnt < HCNT_W'(H_END));
   assign v_act       = (vcnt >= VCNT_W'(V_BEG)) && (vcnt < VCNT_W'(V_END));
   assign valid       = h_act && v_act;
   assign frame_start = (hcnt == '0) && (vcnt == '0);
   assign col         = COL_W'(hcnt - HCNT_W'(H_BEG));
   assign row         = ROW_W'(vcnt - VCNT_W'(V_BEG));

endmodule

// File: rtl/vin_pattern_gen.sv
// Synthetic two-pixel-per-clock RGB888 video source with selectable test
// patterns; drops in at the vin front end in place of the capture path.
module vin_pattern_gen
   import vin_pkg::*;
#(
   parameter int H_ACTIVE  = 800,
   parameter int H_FP      = 8,
   parameter int H_SYNC    = 4,
   parameter int H_BP      = 8,
   parameter int V_ACTIVE  = 1200,
   parameter int V_FP      = 2,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 4,
   parameter int BAR_SHIFT = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   input  logic [7:0]  gray,
   output logic        out_vsync,
   output logic        out_hsync,
   output logic [47:0] out_color,
   output logic        out_valid
);

   localparam int COL_W   = width_of(H_ACTIVE);
   localparam int ROW_W   = width_of(V_ACTIVE);
   // Pixel x and row are widened so the fixed bit picks below always exist.
   localparam int X_MIN   = (BAR_SHIFT + 3 > 8) ? BAR_SHIFT + 3 : 8;
   localparam int X_W     = (COL_W + 1 > X_MIN) ? COL_W + 1 : X_MIN;
   localparam int ROWX_W  = (ROW_W > 4) ? ROW_W : 4;

   logic              hsync;
   logic              vsync;
   logic              valid;
   logic              frame_start;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [X_W-1:0]    x_even;
   logic [X_W-1:0]    x_odd;
   logic [ROWX_W-1:0] row_x;
   pattern_e          sel_q;
   logic [7:0]        gray_q;

   vin_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .COL_W    (COL_W),
      .ROW_W    (ROW_W)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .hsync       (hsync),
      .vsync       (vsync),
      .valid       (valid),
      .frame_start (frame_start),
      .col         (col),
      .row         (row)
   );

   assign x_even = X_W'({col, 1'b0});
   assign x_odd  = X_W'({col, 1'b1});
   assign row_x  = ROWX_W'(row);

   function automatic logic [23:0] pixel(input pattern_e sel,
                                         input logic [7:0] g,
                                         input logic [X_W-1:0] x,
                                         input logic [ROWX_W-1:0] r);
      logic [23:0] rgb;
      case (sel)
         PAT_SOLID: rgb = {g, g, g};
         PAT_RAMP:  rgb = {x[7:0], x[7:0], x[7:0]};
         PAT_BARS:  rgb = BAR_RGB[x[BAR_SHIFT+2:BAR_SHIFT]];
         default:   rgb = (x[3] ^ r[3]) ? 24'hFFFFFF : 24'h000000;
      endcase
      return rgb;
   endfunction

   // Selection is captured only at the frame origin; since the counters sit
   // at the origin while disabled, this also covers the first enabled cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q  <= PAT_SOLID;
         gray_q <= '0;
      end else if (en && frame_start) begin
         sel_q  <= pattern_e'(pattern_sel);
         gray_q <= gray;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_hsync <= 1'b0;
         out_vsync <= 1'b0;
         out_valid <= 1'b0;
         out_color <= '0;
      end else if (!en) begin
         out_hsync <= 1'b0;
         out_vsync <= 1'b0;
         out_valid <= 1'b0;
         out_color <= '0;
      end else begin
         out_hsync <= hsync;
         out_vsync <= vsync;
         out_valid <= valid;
         out_color <= valid ? {pixel(sel_q, gray_q, x_even, row_x),
                               pixel(sel_q, gray_q, x_odd,  row_x)} : '0;
      end
   end

endmodule

// File: tb/tb_vin_pattern_gen.sv
// Self-checking bench for vin_pattern_gen: table-driven pattern frames,
// raster/corner sequences and randomized traffic against a frame-level model.
module tb_vin_pattern_gen;

   localparam int H_ACTIVE  = 4;
   localparam int H_FP      = 1;
   localparam int H_SYNC    = 2;
   localparam int H_BP      = 1;
   localparam int V_ACTIVE  = 3;
   localparam int V_FP      = 1;
   localparam int V_SYNC    = 1;
   localparam int V_BP      = 1;
   localparam int BAR_SHIFT = 1;
   localparam int HT        = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int VT        = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int FRAME     = HT * VT;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  pattern_sel;
   logic [7:0]  gray;
   logic        out_vsync;
   logic        out_hsync;
   logic [47:0] out_color;
   logic        out_valid;

   int errors = 0;
   int checks = 0;

   // Model state: cycles since the current frame sequence began, and the
   // selection latched at the most recent frame origin.
   int         m_t;
   logic [1:0] m_sel;
   logic [7:0] m_gray;

   logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   typedef struct {
      logic [1:0]  sel;
      logic [7:0]  gray;
      int          row;
      int          col;
      logic [47:0] exp;
   } vec_t;

   vec_t        vecs [16];
   logic [47:0] cap [FRAME];
   int          ncap;

   vin_pattern_gen #(
      .H_ACTIVE  (H_ACTIVE),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_ACTIVE  (V_ACTIVE),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP),
      .BAR_SHIFT (BAR_SHIFT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .pattern_sel (pattern_sel),
      .gray        (gray),
      .out_vsync   (out_vsync),
      .out_hsync   (out_hsync),
      .out_color   (out_color),
      .out_valid   (out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pix_model(input int x, input int r,
                                             input logic [1:0] sel,
                                             input logic [7:0] g);
      logic [7:0] lv;
      lv = 8'(x % 256);
      case (sel)
         2'd0:    return {g, g, g};
         2'd1:    return {lv, lv, lv};
         2'd2:    return bar_rgb[(x >> BAR_SHIFT) % 8];
         default: return ((((x >> 3) ^ (r >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [47:0] act,
                               input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_t    = 0;
      m_sel  = 2'd0;
      m_gray = 8'd0;
   endtask

   // Drives one cycle of inputs, advances the model across the edge and
   // compares all four outputs just after the edge.
   task automatic apply_stimulus(input logic en_v, input logic [1:0] sel_v,
                                 input logic [7:0] gray_v);
      int h, v, c, r;
      logic        e_hs, e_vs, e_vld;
      logic [47:0] e_col;
      en          = en_v;
      pattern_sel = sel_v;
      gray        = gray_v;
      @(posedge clk);
      e_hs = 1'b0; e_vs = 1'b0; e_vld = 1'b0; e_col = '0;
      if (en_v) begin
         h = m_t % HT;
         v = (m_t / HT) % VT;
         if (h == 0 && v == 0) begin
            m_sel  = sel_v;
            m_gray = gray_v;
         end
         c     = h - (H_SYNC + H_BP);
         r     = v - (V_SYNC + V_BP);
         e_hs  = (h < H_SYNC);
         e_vs  = (v < V_SYNC);
         e_vld = (c >= 0 && c < H_ACTIVE && r >= 0 && r < V_ACTIVE);
         if (e_vld)
            e_col = {pix_model(2 * c, r, m_sel, m_gray), pix_model(2 * c + 1, r, m_sel, m_gray)};
         m_t++;
      end else begin
         m_t = 0;
      end
      #1;
      check_output("hsync", 48'(out_hsync), 48'(e_hs));
      check_output("vsync", 48'(out_vsync), 48'(e_vs));
      check_output("valid", 48'(out_valid), 48'(e_vld));
      check_output("color", out_color, e_col);
   endtask

   // One disabled cycle, then a full enabled frame plus the trailing edge,
   // collecting every valid word in order.
   task automatic capture_frame(input logic [1:0] sel_v, input logic [7:0] gray_v);
      apply_stimulus(1'b0, sel_v, gray_v);
      ncap = 0;
      for (int i = 0; i < FRAME; i++) begin
         apply_stimulus(1'b1, sel_v, gray_v);
         if (out_valid && ncap < FRAME) begin
            cap[ncap] = out_color;
            ncap++;
         end
      end
   endtask

   initial begin
      logic        hs_log  [2*FRAME];
      logic        vs_log  [2*FRAME];
      logic        vld_log [2*FRAME];
      int          cnt;
      int          t_pre;
      logic        seen_next;

      vecs[0]  = '{2'd0, 8'h5A, 0, 0, 48'h5A5A5A_5A5A5A};
      vecs[1]  = '{2'd0, 8'h5A, 2, 3, 48'h5A5A5A_5A5A5A};
      vecs[2]  = '{2'd0, 8'hC3, 1, 2, 48'hC3C3C3_C3C3C3};
      vecs[3]  = '{2'd1, 8'h00, 0, 0, 48'h000000_010101};
      vecs[4]  = '{2'd1, 8'h00, 0, 1, 48'h020202_030303};
      vecs[5]  = '{2'd1, 8'h00, 1, 2, 48'h040404_050505};
      vecs[6]  = '{2'd1, 8'h00, 2, 3, 48'h060606_070707};
      vecs[7]  = '{2'd2, 8'h00, 0, 0, 48'hFFFFFF_FFFFFF};
      vecs[8]  = '{2'd2, 8'h00, 1, 1, 48'hFFFF00_FFFF00};
      vecs[9]  = '{2'd2, 8'h00, 2, 2, 48'h00FFFF_00FFFF};
      vecs[10] = '{2'd2, 8'h00, 0, 3, 48'h00FF00_00FF00};
      vecs[11] = '{2'd3, 8'h00, 0, 0, 48'h000000_000000};
      vecs[12] = '{2'd3, 8'h00, 2, 3, 48'h000000_000000};
      vecs[13] = '{2'd1, 8'hFF, 1, 0, 48'h000000_010101};
      vecs[14] = '{2'd2, 8'h77, 2, 1, 48'hFFFF00_FFFF00};
      vecs[15] = '{2'd0, 8'h01, 2, 0, 48'h010101_010101};

      rst = 1'b1; en = 1'b0; pattern_sel = 2'd0; gray = 8'd0;
      model_reset();
      #1;
      check_output("reset_hsync", 48'(out_hsync), 48'd0);
      check_output("reset_vsync", 48'(out_vsync), 48'd0);
      check_output("reset_valid", 48'(out_valid), 48'd0);
      check_output("reset_color", out_color, 48'd0);
      #22;
      rst = 1'b0;
      @(negedge clk);

      // Raster: two frames straight out of reset.
      for (int i = 0; i < 2 * FRAME; i++) begin
         apply_stimulus(1'b1, 2'd0, 8'h5A);
         hs_log[i]  = out_hsync;
         vs_log[i]  = out_vsync;
         vld_log[i] = out_valid;
         if (i == 0) begin
            check_output("first_edge_hsync", 48'(out_hsync), 48'd1);
            check_output("first_edge_vsync", 48'(out_vsync), 48'd1);
         end
      end
      for (int l = 0; l < 2 * VT; l++) begin
         cnt = 0;
         for (int k = 0; k < HT; k++) cnt += int'(hs_log[l * HT + k]);
         check_output($sformatf("hsync_per_line%0d", l), 48'(cnt), 48'(H_SYNC));
         cnt = 0;
         for (int k = 0; k < HT; k++) cnt += int'(vld_log[l * HT + k]);
         check_output($sformatf("valid_per_line%0d", l), 48'(cnt),
                      ((l % VT) >= 2 && (l % VT) <= 4) ? 48'd4 : 48'd0);
      end
      for (int f = 0; f < 2; f++) begin
         cnt = 0;
         for (int k = 0; k < HT; k++) cnt += int'(vs_log[f * FRAME + k]);
         check_output($sformatf("vsync_run_frame%0d", f), 48'(cnt), 48'd8);
         cnt = 0;
         for (int k = 0; k < FRAME; k++) cnt += int'(vs_log[f * FRAME + k]);
         check_output($sformatf("vsync_total_frame%0d", f), 48'(cnt), 48'd8);
         cnt = 0;
         for (int k = 0; k < FRAME; k++) cnt += int'(vld_log[f * FRAME + k]);
         check_output($sformatf("valid_words_frame%0d", f), 48'(cnt), 48'd12);
      end

      // Table-driven pattern words.
      foreach (vecs[n]) begin
         capture_frame(vecs[n].sel, vecs[n].gray);
         check_output($sformatf("vec%0d_count", n), 48'(ncap), 48'd12);
         check_output($sformatf("vec%0d_word", n),
                      cap[vecs[n].row * H_ACTIVE + vecs[n].col], vecs[n].exp);
      end

      // Select change during active line 3 must wait for the next frame.
      apply_stimulus(1'b0, 2'd0, 8'h5A);
      seen_next = 1'b0;
      for (int i = 0; i < FRAME + 4 * HT; i++) begin
         t_pre = m_t;
         apply_stimulus(1'b1, (t_pre >= 3 * HT + 4) ? 2'd1 : 2'd0, 8'h5A);
         if (out_valid && t_pre < FRAME && t_pre >= 3 * HT + 4)
            check_output("midframe_still_solid", out_color, 48'h5A5A5A_5A5A5A);
         if (out_valid && t_pre >= FRAME && !seen_next) begin
            check_output("next_frame_ramp", out_color, 48'h000000_010101);
            seen_next = 1'b1;
         end
      end
      check_output("next_frame_seen", 48'(seen_next), 48'd1);

      // Abort mid-line, restart, then asynchronous reset mid-frame.
      apply_stimulus(1'b0, 2'd2, 8'h00);
      for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 2'd2, 8'h00);
      check_output("pre_abort_valid", 48'(out_valid), 48'd1);
      apply_stimulus(1'b0, 2'd2, 8'h00);
      check_output("abort_all_zero",
                   {out_color[44:0], out_hsync, out_vsync, out_valid} | 48'(out_color[47:45]), 48'd0);
      apply_stimulus(1'b1, 2'd2, 8'h00);
      check_output("restart_hsync", 48'(out_hsync), 48'd1);
      check_output("restart_vsync", 48'(out_vsync), 48'd1);
      apply_stimulus(1'b1, 2'd2, 8'h00);
      #2;
      rst = 1'b1;
      #1;
      check_output("async_rst_hsync", 48'(out_hsync), 48'd0);
      check_output("async_rst_vsync", 48'(out_vsync), 48'd0);
      check_output("async_rst_valid", 48'(out_valid), 48'd0);
      check_output("async_rst_color", out_color, 48'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(1'b1, 2'd3, 8'h00);
      check_output("post_rst_hsync", 48'(out_hsync), 48'd1);
      check_output("post_rst_vsync", 48'(out_vsync), 48'd1);

      // Randomized traffic: sparse en drops, selection changing freely.
      for (int i = 0; i < 3000; i++)
         apply_stimulus(($urandom_range(0, 199) != 0), 2'($urandom_range(0, 3)),
                        8'($urandom_range(0, 255)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vin_pattern_gen.md
# vin_pattern_gen

Synthetic video source for the vin input path. It produces the same stream the color mixer consumes: vsync, hsync, a 48-bit two-pixel RGB888 word and valid. It drops in at the vin front end in place of the capture path, so panel bring-up and colormixer/pipeline debug can run without a live video source. It generates configurable raster timing from horizontal/vertical counters and fills active video with one of four selectable test patterns.

## Interface
- H_ACTIVE, 800: active clocks per line (each clock = 2 pixels)
- H_FP, 8: horizontal front porch, clocks
- H_SYNC, 4: hsync width, clocks
- H_BP, 8: horizontal back porch, clocks
- V_ACTIVE, 1200: active lines
- V_FP, 2: vertical front porch, lines
- V_SYNC, 2: vsync width, lines
- V_BP, 4: vertical back porch, lines
- BAR_SHIFT, 7: log2 of color-bar width in pixels

Ports:
- clk  in  1  pixel-pair clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  generator enable
- pattern_sel  in  2  0 solid, 1 ramp, 2 color bars, 3 checkerboard
- gray  in  8  level for solid pattern
- out_vsync  out  1  vertical sync, active high
- out_hsync  out  1  horizontal sync, active high
- out_color  out  48  {R,G,B} even pixel [47:24], odd pixel [23:0], 8b per channel
- out_valid  out  1  active-video qualifier

## Operation
- hcnt counts 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP.
- vcnt counts 0..V_TOTAL-1, where V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Both counters advance on every clk edge with en=1. hcnt wraps to 0 and increments vcnt. vcnt wraps to 0 at V_TOTAL-1 when hcnt wraps.
- hsync is asserted when hcnt < H_SYNC. vsync is asserted for whole lines with vcnt < V_SYNC.
- valid is asserted when H_SYNC+H_BP ≤ hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP ≤ vcnt < V_SYNC+V_BP+V_ACTIVE.
- Coordinates: col = hcnt-(H_SYNC+H_BP); row = vcnt-(V_SYNC+V_BP). Even pixel x = 2·col, odd pixel x = 2·col+1.
- Patterns are computed per pixel (even and odd independently):
  - solid: R=G=B=gray.
  - ramp: R=G=B=x[7:0], wrapping every 256 pixels.
  - bars: index = x[BAR_SHIFT+2:BAR_SHIFT]. Indices 0..7 map to white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - checker: FFFFFF if x[3]^row[3], else 000000.
- pattern_sel and gray are latched only when hcnt=0 and vcnt=0 (frame start), and on the first cycle after en rises. A pattern change therefore never occurs mid-frame.
- out_color is 0 whenever valid is 0.
- en=0: counters are forced to 0 and all outputs go to 0 on the next edge. When en re-asserts, a fresh frame starts at hcnt=vcnt=0. If en drops mid-frame, the frame is aborted and no partial-frame completion occurs.
- Coordinate width rules: col and row use clog2 of their ranges. x is col extended by one bit; no overflow is possible.

## Timing
- Reset value of every output is 0, as is every counter and latched selection.
- All outputs are registered, with one cycle of latency from counter state. The output after edge k reflects the hcnt/vcnt value held before edge k.
- The first edge after rst release with en=1 produces out_hsync=1 and out_vsync=1 (counter state 0,0).
- There is no backpressure. The downstream must accept one word per cycle while out_valid=1.
- If rst asserts mid-frame, all outputs clear immediately (asynchronously) and the frame restarts from 0,0 after release.

## Structure
- Shared package vin_pkg holds the pattern_sel encodings (PAT_SOLID=0, PAT_RAMP=1, PAT_BARS=2, PAT_CHECK=3) and the 8-entry color-bar RGB constants.
- One sub-module, vin_timing_gen, holds the counters and generates sync, valid, col and row. The pixel-pattern logic stays in the top module.

## Test plan
Common parameters: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); BAR_SHIFT=1.
- Raster check: reset, en=1, run 2 frames. Expect:
  - out_hsync high 2 of every 8 cycles.
  - out_vsync high for 8 consecutive cycles every 48.
  - out_valid high 4 cycles per line on lines 2–4 only, so 12 valid words per frame.
- Solid: pattern_sel=0, gray=8'h5A. Every valid word = 48'h5A5A5A_5A5A5A; every invalid cycle gives out_color=0.
- Ramp: pattern_sel=1. Words on each active line are 000000_010101, 020202_030303, 040404_050505, 060606_070707.
- Bars: pattern_sel=2. Words are FFFFFF_FFFFFF, FFFF00_FFFF00, 00FFFF_00FFFF, 00FF00_00FF00.
- Mid-frame select change: switch pattern_sel 0→1 during active line 3. The current frame stays solid; the ramp appears from the first valid word of the next frame.
- Abort/reset: drop en mid-line. All outputs are 0 next cycle. Re-assert en: the next edge shows hsync=vsync=1 with a full frame following. Then pulse rst mid-frame: outputs clear without waiting for a clk edge.
